// File: rtl/freq_meter_pkg.sv
// Shared types and default parameters for the freq_meter period/lock monitor.
package freq_meter_pkg;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_LOCK_COUNT  = 4;
    localparam int unsigned DEF_TOL         = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_e;

endpackage

// File: rtl/freq_meter_sync.sv
// Input capture and rising-edge detect for freq_meter.
// FREQ_METER_SYNC_EN selects a SYNC_STAGES-deep synchronizer instead of a single capture flop.
module freq_meter_sync
    import freq_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic in_sig,
    output logic rise_c
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("freq_meter_sync: SYNC_STAGES must be at least 2");
    end

    logic level;
    logic prev;

`ifdef FREQ_METER_SYNC_EN
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], in_sig};
        end
    end

    assign level = chain[SYNC_STAGES-1];
`else
    logic cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap <= 1'b0;
        end else begin
            cap <= in_sig;
        end
    end

    assign level = cap;
`endif

    // Previous sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise_c = level & ~prev;

endmodule

// File: rtl/freq_meter.sv
// Measures rising-edge-to-rising-edge period of in_sig in clk cycles and tracks lock.
// Define FREQ_METER_SYNC_EN when in_sig is asynchronous to clk.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int unsigned TOL         = DEF_TOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_sig,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow
);

    localparam int unsigned        MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_COUNT);
    localparam logic [CNT_W:0]     TOL_W      = (CNT_W+1)'(TOL);

    if (LOCK_COUNT < 1) begin : g_bad_lock_count
        $error("freq_meter: LOCK_COUNT must be at least 1");
    end

    logic rise_c;

    freq_meter_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .in_sig (in_sig),
        .rise_c (rise_c)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               has_prev_q, has_prev_d;
    logic [CNT_W-1:0]   period_d;
    logic               valid_d, locked_d, overflow_d;

    // Candidate period and its distance from the previous one, one bit wider so nothing wraps
    logic [CNT_W:0] new_period_c;
    logic [CNT_W:0] diff_c;
    logic           in_tol_c;

    always_comb begin
        new_period_c = {1'b0, cnt_q} + (CNT_W+1)'(1);
        if (new_period_c >= {1'b0, period}) begin
            diff_c = new_period_c - {1'b0, period};
        end else begin
            diff_c = {1'b0, period} - new_period_c;
        end
        in_tol_c = has_prev_q && (diff_c <= TOL_W);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        has_prev_d = has_prev_q;
        period_d   = period;
        valid_d    = 1'b0;
        locked_d   = locked;
        overflow_d = overflow;

        if (!en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            match_d    = '0;
            has_prev_d = 1'b0;
            locked_d   = 1'b0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;

                ARM: begin
                    cnt_d      = '0;
                    match_d    = '0;
                    has_prev_d = 1'b0;
                    if (rise_c) begin
                        state_d    = MEASURE;
                        overflow_d = 1'b0;
                    end
                end

                MEASURE, LOCKED: begin
                    if (rise_c) begin
                        period_d   = CNT_W'(new_period_c);
                        valid_d    = 1'b1;
                        cnt_d      = '0;
                        has_prev_d = 1'b1;
                        if (in_tol_c) begin
                            match_d = (match_q == MATCH_FULL) ? match_q : match_q + MATCH_W'(1);
                            if (match_d == MATCH_FULL) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            match_d  = '0;
                            locked_d = 1'b0;
                            state_d  = MEASURE;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // No edge within MAX cycles: drop lock and re-arm on the next edge
                        overflow_d = 1'b1;
                        locked_d   = 1'b0;
                        match_d    = '0;
                        cnt_d      = '0;
                        state_d    = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            match_q      <= '0;
            has_prev_q   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            has_prev_q   <= has_prev_d;
            period       <= period_d;
            period_valid <= valid_d;
            locked       <= locked_d;
            overflow     <= overflow_d;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter (CNT_W=16 and CNT_W=4 instances).
module tb_freq_meter;

`ifdef FREQ_METER_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, en, in_sig;
    logic [15:0] period;
    logic        period_valid, locked, overflow;
    logic [3:0]  period4;
    logic        period_valid4, locked4, overflow4;

    freq_meter #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in_sig       (in_sig),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .overflow     (overflow)
    );

    freq_meter #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .in_sig       (in_sig),
        .period       (period4),
        .period_valid (period_valid4),
        .locked       (locked4),
        .overflow     (overflow4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Report logs captured on the falling edge
    int q_per[$], q_lock[$], q_cyc[$];
    int q4_per[$], q4_lock[$], q4_cyc[$];
    int ovf4_rise[$], lock4_fall[$];
    logic ovf4_d = 1'b0, lock4_d = 1'b0;

    always @(negedge clk) begin
        if (period_valid) begin
            q_per.push_back(int'(period));
            q_lock.push_back(int'(locked));
            q_cyc.push_back(cyc);
        end
        if (period_valid4) begin
            q4_per.push_back(int'(period4));
            q4_lock.push_back(int'(locked4));
            q4_cyc.push_back(cyc);
        end
        if (overflow4 && !ovf4_d) ovf4_rise.push_back(cyc);
        if (!locked4 && lock4_d) lock4_fall.push_back(cyc);
        ovf4_d = overflow4;
        lock4_d = locked4;
    end

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waves(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            in_sig = 1'b1;
            repeat (hi) tick();
            in_sig = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic clear_logs();
        q_per.delete();  q_lock.delete();  q_cyc.delete();
        q4_per.delete(); q4_lock.delete(); q4_cyc.delete();
        ovf4_rise.delete(); lock4_fall.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; in_sig = 1'b0;
        repeat (3) tick();
        rst = 1'b0; en = 1'b1;
        repeat (3) tick();
        clear_logs();
    endtask

    int n_edge;

    initial begin
        rst = 1'b1; en = 1'b0; in_sig = 1'b0;
        repeat (3) tick();
        check("rst_period",   int'(period), 0);
        check("rst_valid",    int'(period_valid), 0);
        check("rst_locked",   int'(locked), 0);
        check("rst_overflow", int'(overflow), 0);

        // Divide-by-2 input: every period is 2, lock on the 5th report
        do_reset();
        waves(1, 1, 8);
        repeat (4) tick();
        check("div2_count", q_per.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("div2_per[%0d]", i), qat(q_per, i), 2);
            check($sformatf("div2_lock[%0d]", i), qat(q_lock, i), (i >= 4) ? 1 : 0);
        end

        // Period 10, one glitch of 14, relock after 4 more in-tolerance periods
        do_reset();
        waves(5, 5, 7);
        waves(7, 7, 1);
        waves(5, 5, 5);
        waves(1, 4, 1);
        repeat (4) tick();
        check("glitch_count", q_per.size(), 13);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("glitch_per[%0d]", i), qat(q_per, i), (i == 7) ? 14 : 10);
            check($sformatf("glitch_lock[%0d]", i), qat(q_lock, i),
                  ((i >= 4 && i <= 6) || i == 12) ? 1 : 0);
        end

        // CNT_W=4: lock, then hold low until overflow fires at cnt=14
        do_reset();
        waves(5, 5, 5);
        waves(1, 29, 1);
        check("ovf_reports", q4_per.size(), 5);
        check("ovf_prelock", qat(q4_lock, 4), 1);
        check("ovf_rise_cnt", ovf4_rise.size(), 1);
        check("ovf_delay", qat(ovf4_rise, 0) - qat(q4_cyc, 4), 15);
        check("ovf_lock_drop", qat(lock4_fall, 0), qat(ovf4_rise, 0));
        check("ovf_flag", int'(overflow4), 1);
        check("ovf_locked", int'(locked4), 0);
        q4_per.delete(); q4_lock.delete(); q4_cyc.delete();
        waves(3, 12, 2);
        waves(1, 4, 1);
        repeat (4) tick();
        check("max_count", q4_per.size(), 2);
        check("max_per0", qat(q4_per, 0), 15);
        check("max_per1", qat(q4_per, 1), 15);
        check("max_ovf_clear", int'(overflow4), 0);
        check("max_no_ovf", ovf4_rise.size(), 1);

        // Enable dropped for 3 cycles mid-measurement
        do_reset();
        waves(5, 5, 5);
        in_sig = 1'b1;
        repeat (5) tick();
        in_sig = 1'b0;
        repeat (2) tick();
        check("en_prelock", int'(locked), 1);
        en = 1'b0;
        tick();
        check("en_unlock", int'(locked), 0);
        check("en_hold0", int'(period), 10);
        repeat (2) tick();
        check("en_hold1", int'(period), 10);
        en = 1'b1;
        clear_logs();
        repeat (3) tick();
        waves(5, 5, 2);
        waves(1, 4, 1);
        repeat (4) tick();
        check("en_count", q_per.size(), 2);
        check("en_per0", qat(q_per, 0), 10);
        check("en_per1", qat(q_per, 1), 10);

        // One-cycle reset while locked, then input-path latency
        do_reset();
        waves(5, 5, 5);
        in_sig = 1'b1;
        repeat (5) tick();
        in_sig = 1'b0;
        repeat (2) tick();
        check("rst2_prelock", int'(locked), 1);
        rst = 1'b1;
        tick();
        check("rst2_period",   int'(period), 0);
        check("rst2_valid",    int'(period_valid), 0);
        check("rst2_locked",   int'(locked), 0);
        check("rst2_overflow", int'(overflow), 0);
        rst = 1'b0;
        clear_logs();
        repeat (3) tick();
        waves(5, 5, 1);
        n_edge = cyc + 1;
        waves(5, 5, 1);
        waves(1, 4, 1);
        repeat (4) tick();
        check("lat_count", q_per.size(), 2);
        check("lat_edge", qat(q_cyc, 0), n_edge + S);
        check("lat_per0", qat(q_per, 0), 10);
        check("lat_per1", qat(q_per, 1), 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
